// File: rtl/timer_pkg.sv
// Shared definitions for the timer datapath: digit width, the legal range of
// the seconds-tens stage, keypad width and the entry FSM state type.
package timer_pkg;

  localparam int DIGIT_W      = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int KEY_W        = 10;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOAD
  } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button vector, plus a
// previous-sample register so that a press (all-zero -> non-zero) can be
// detected as a single-cycle pulse no matter how long the button is held.
module btn_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic [W-1:0] raw,
  output logic [W-1:0] level,
  output logic         rise
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic [W-1:0] prev;

  // Synchronise the raw input and remember last cycle's synchronised value.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = (|sync) && !(|prev);

endmodule

// File: rtl/timer_digit_entry.sv
// Keypad entry stage for the M:ST:SO timer. Synchronises the keypad and the
// start/cancel buttons, shifts accepted digits into a three-digit register,
// and on a valid start drives the counters' data buses with a one-cycle
// active-low load strobe.
module timer_digit_entry #(
  parameter int DIGIT_W      = 4,
  parameter int NDIGITS      = 3,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [9:0]         key_in,
  input  logic               start_in,
  input  logic               cancel_in,
  input  logic               busy,
  output logic [DIGIT_W-1:0] min_digit,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               loadn,
  output logic               entry_valid,
  output logic               key_err
);

  import timer_pkg::*;

  localparam int COUNT_W = $clog2(NDIGITS + 1);

  logic [KEY_W-1:0]   key_level;
  logic               key_rise;
  logic               start_level_unused;
  logic               start_rise;
  logic               cancel_level_unused;
  logic               cancel_rise;
  logic               key_onehot;
  logic [DIGIT_W-1:0] key_code;
  logic [COUNT_W-1:0] count;
  state_t             state;

  btn_sync_edge #(.W(KEY_W)) u_key_sync (
    .clk   (clk),
    .clrn  (clrn),
    .raw   (key_in),
    .level (key_level),
    .rise  (key_rise)
  );

  btn_sync_edge #(.W(1)) u_start_sync (
    .clk   (clk),
    .clrn  (clrn),
    .raw   (start_in),
    .level (start_level_unused),
    .rise  (start_rise)
  );

  btn_sync_edge #(.W(1)) u_cancel_sync (
    .clk   (clk),
    .clrn  (clrn),
    .raw   (cancel_in),
    .level (cancel_level_unused),
    .rise  (cancel_rise)
  );

  // Encode the synchronised one-hot keypad to its BCD digit value.
  always_comb begin
    key_code = '0;
    for (int k = 0; k < KEY_W; k++) begin
      if (key_level[k]) key_code = DIGIT_W'(k);
    end
  end

  assign key_onehot  = $onehot(key_level);
  assign entry_valid = (count != '0) && (sec_tens <= DIGIT_W'(SEC_TENS_MAX));

  // Entry FSM: cancel beats start beats key; LOAD lasts one cycle then clears.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      count     <= '0;
      min_digit <= '0;
      sec_tens  <= '0;
      sec_ones  <= '0;
      loadn     <= 1'b1;
      key_err   <= 1'b0;
    end else begin
      key_err <= 1'b0;
      loadn   <= 1'b1;
      case (state)
        IDLE, ENTRY: begin
          if (cancel_rise) begin
            state     <= IDLE;
            count     <= '0;
            min_digit <= '0;
            sec_tens  <= '0;
            sec_ones  <= '0;
          end else if (start_rise) begin
            if (!busy) begin
              if (state == ENTRY && entry_valid) begin
                state <= LOAD;
                loadn <= 1'b0;
              end else begin
                key_err <= 1'b1;
              end
            end
          end else if (key_rise && !busy) begin
            if (!key_onehot || count >= COUNT_W'(NDIGITS)) begin
              key_err <= 1'b1;
            end else begin
              min_digit <= sec_tens;
              sec_tens  <= sec_ones;
              sec_ones  <= key_code;
              count     <= count + COUNT_W'(1);
              state     <= ENTRY;
            end
          end
        end
        LOAD: begin
          state     <= IDLE;
          count     <= '0;
          min_digit <= '0;
          sec_tens  <= '0;
          sec_ones  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_digit_entry.sv
// Self-checking bench for timer_digit_entry. Stimulus is issued as whole
// button transactions; a list-of-digits model predicts the entry, the number
// of key_err pulses and the load strobes each transaction should produce.
module tb_timer_digit_entry;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [9:0] key_in = '0;
  logic       start_in = 1'b0;
  logic       cancel_in = 1'b0;
  logic       busy = 1'b0;
  logic [3:0] min_digit, sec_tens, sec_ones;
  logic       loadn, entry_valid, key_err;

  timer_digit_entry dut (
    .clk         (clk),
    .clrn        (clrn),
    .key_in      (key_in),
    .start_in    (start_in),
    .cancel_in   (cancel_in),
    .busy        (busy),
    .min_digit   (min_digit),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .loadn       (loadn),
    .entry_valid (entry_valid),
    .key_err     (key_err)
  );

  always #5 clk = ~clk;

  localparam int K_KEY = 0, K_MULTI = 1, K_START = 2, K_CANCEL = 3, K_KEYSTART = 4;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the digits entered so far, oldest first.
  int digits[$];
  int exp_err, exp_loads;
  int exp_lm, exp_lt, exp_lo;

  int err_seen, load_seen, load_bad;

  // Count strobes seen by the counters and check the data they would sample.
  always @(negedge clk) begin
    if (clrn) begin
      if (key_err) err_seen++;
      if (!loadn) begin
        load_seen++;
        if (min_digit != exp_lm[3:0] || sec_tens != exp_lt[3:0] || sec_ones != exp_lo[3:0])
          load_bad++;
      end
    end
  end

  task automatic checkOutput(input string tag, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic int dig(input int pos);
    // pos 0 = seconds-ones, 1 = seconds-tens, 2 = minutes
    if (digits.size() > pos) return digits[digits.size() - 1 - pos];
    return 0;
  endfunction

  function automatic bit model_valid();
    return digits.size() != 0 && dig(1) <= 5;
  endfunction

  function automatic void model_apply(input int kind, input int kval, input bit bsy);
    exp_err = 0;
    exp_loads = 0;
    case (kind)
      K_KEY: if (!bsy) begin
        if (digits.size() < 3) digits.push_back(kval);
        else exp_err = 1;
      end
      K_MULTI: if (!bsy) exp_err = 1;
      K_START, K_KEYSTART: if (!bsy) begin
        if (model_valid()) begin
          exp_loads = 1;
          exp_lm = dig(2); exp_lt = dig(1); exp_lo = dig(0);
          digits.delete();
        end else begin
          exp_err = 1;
        end
      end
      K_CANCEL: digits.delete();
      default: ;
    endcase
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".min"}, int'(min_digit), dig(2));
    checkOutput({tag, ".tens"}, int'(sec_tens), dig(1));
    checkOutput({tag, ".ones"}, int'(sec_ones), dig(0));
    checkOutput({tag, ".valid"}, int'(entry_valid), int'(model_valid()));
    checkOutput({tag, ".key_err_pulses"}, err_seen, exp_err);
    checkOutput({tag, ".load_pulses"}, load_seen, exp_loads);
    checkOutput({tag, ".load_data_bad"}, load_bad, 0);
  endtask

  // Drive one button transaction, let it settle, then check against the model.
  task automatic applyStimulus(input string tag, input int kind, input int kval,
                               input int hold, input bit bsy);
    logic [9:0] kv;
    int a, b;
    err_seen = 0; load_seen = 0; load_bad = 0;
    model_apply(kind, kval, bsy);
    kv = '0;
    if (kind == K_MULTI) begin
      a = kval % 10;
      b = (a + 1 + int'($urandom_range(0, 8))) % 10;
      kv[a] = 1'b1;
      kv[b] = 1'b1;
    end else if (kind == K_KEY || kind == K_KEYSTART) begin
      kv[kval] = 1'b1;
    end
    @(negedge clk);
    busy      = bsy;
    key_in    = kv;
    start_in  = (kind == K_START || kind == K_KEYSTART);
    cancel_in = (kind == K_CANCEL);
    repeat (hold) @(negedge clk);
    key_in = '0; start_in = 1'b0; cancel_in = 1'b0;
    repeat (6) @(negedge clk);
    busy = 1'b0;
    checkAll(tag);
  endtask

  initial begin
    int kind, r;
    bit found;
    exp_err = 0; exp_loads = 0; exp_lm = 0; exp_lt = 0; exp_lo = 0;
    err_seen = 0; load_seen = 0; load_bad = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset.loadn", int'(loadn), 1);
    checkOutput("reset.key_err", int'(key_err), 0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    checkAll("reset");

    // Digit update lands exactly on the third posedge after the key asserts.
    key_in = 10'b0000000010;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("latency.edge2", int'(sec_ones), 0);
    @(posedge clk); #1;
    checkOutput("latency.edge3", int'(sec_ones), 1);
    @(negedge clk); @(negedge clk);
    key_in = '0;
    repeat (6) @(negedge clk);
    model_apply(K_KEY, 1, 1'b0);
    checkAll("latency");

    applyStimulus("k3", K_KEY, 3, 5, 1'b0);
    applyStimulus("k0", K_KEY, 0, 5, 1'b0);
    applyStimulus("start130", K_START, 0, 2, 1'b0);

    applyStimulus("k0b", K_KEY, 0, 3, 1'b0);
    applyStimulus("k7", K_KEY, 7, 3, 1'b0);
    applyStimulus("k5", K_KEY, 5, 3, 1'b0);
    applyStimulus("start075", K_START, 0, 2, 1'b0);
    applyStimulus("k2full", K_KEY, 2, 3, 1'b0);
    applyStimulus("cancel", K_CANCEL, 0, 2, 1'b0);
    applyStimulus("multi12", K_MULTI, 1, 3, 1'b0);
    applyStimulus("busy4", K_KEY, 4, 3, 1'b1);
    applyStimulus("k4", K_KEY, 4, 3, 1'b0);
    applyStimulus("k5b", K_KEY, 5, 3, 1'b0);
    applyStimulus("keystart045", K_KEYSTART, 9, 3, 1'b0);

    // Reset asserted while the load strobe is low.
    applyStimulus("r1", K_KEY, 1, 2, 1'b0);
    applyStimulus("r3", K_KEY, 3, 2, 1'b0);
    applyStimulus("r0", K_KEY, 0, 2, 1'b0);
    @(negedge clk);
    start_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (!loadn) found = 1'b1;
    end
    checkOutput("midload.strobe_seen", int'(found), 1);
    clrn = 1'b0;
    #1;
    checkOutput("midload.loadn", int'(loadn), 1);
    checkOutput("midload.digits", int'({min_digit, sec_tens, sec_ones}), 0);
    @(negedge clk);
    start_in = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    digits.delete();
    repeat (4) @(negedge clk);
    applyStimulus("idle_start", K_START, 0, 2, 1'b0);
    applyStimulus("after_reset_key", K_KEY, 4, 2, 1'b0);

    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50)      kind = K_KEY;
      else if (r < 58) kind = K_MULTI;
      else if (r < 75) kind = K_START;
      else if (r < 85) kind = K_CANCEL;
      else             kind = K_KEYSTART;
      applyStimulus($sformatf("rnd%0d", t), kind, int'($urandom_range(0, 9)),
                    int'($urandom_range(1, 4)), ($urandom_range(0, 99) < 12));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
